// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one request/response transaction per
// load/store, with store lane alignment, load extraction/extension and misalign rejection.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_wmask,
  input  logic [2:0]        req_width,
  output logic              req_stall,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              misalign,
  output logic              mem_rw_valid,
  input  logic              mem_rw_ready,
  output logic              mem_rw_wen,
  output logic [ADDR_W-1:0] mem_rw_addr,
  output logic [DATA_W-1:0] mem_rw_wdata,
  output logic [7:0]        mem_rw_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  localparam logic [2:0] WidthDw  = 3'd1;
  localparam logic [2:0] WidthW   = 3'd2;
  localparam logic [2:0] WidthHw  = 3'd3;
  localparam logic [2:0] WidthB   = 3'd4;
  localparam logic [2:0] WidthUw  = 3'd5;
  localparam logic [2:0] WidthUhw = 3'd6;
  localparam logic [2:0] WidthUb  = 3'd7;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q;
  logic [2:0]        width_q;
  logic              req_misalign;
  logic [DATA_W-1:0] rd_shifted;
  logic [DATA_W-1:0] ld_ext;

  assign req_stall = req_valid && (state_q != StDone);

  always_comb begin
    req_misalign = 1'b1;
    case (req_width)
      WidthDw:           req_misalign = (req_addr[2:0] != 3'd0);
      WidthW,  WidthUw:  req_misalign = (req_addr[1:0] != 2'd0);
      WidthHw, WidthUhw: req_misalign = req_addr[0];
      WidthB,  WidthUb:  req_misalign = 1'b0;
      default:           req_misalign = 1'b1;
    endcase
  end

  // The registered request address supplies the byte offset for extraction.
  always_comb begin
    rd_shifted = mem_resp_rdata >> {mem_rw_addr[2:0], 3'b000};
    ld_ext     = rd_shifted;
    case (width_q)
      WidthB:   ld_ext = {{(DATA_W-8){rd_shifted[7]}}, rd_shifted[7:0]};
      WidthUb:  ld_ext = {{(DATA_W-8){1'b0}}, rd_shifted[7:0]};
      WidthHw:  ld_ext = {{(DATA_W-16){rd_shifted[15]}}, rd_shifted[15:0]};
      WidthUhw: ld_ext = {{(DATA_W-16){1'b0}}, rd_shifted[15:0]};
      WidthW:   ld_ext = {{(DATA_W-32){rd_shifted[31]}}, rd_shifted[31:0]};
      WidthUw:  ld_ext = {{(DATA_W-32){1'b0}}, rd_shifted[31:0]};
      default:  ld_ext = rd_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      width_q      <= 3'd0;
      mem_rw_valid <= 1'b0;
      mem_rw_wen   <= 1'b0;
      mem_rw_addr  <= '0;
      mem_rw_wdata <= '0;
      mem_rw_wmask <= 8'h00;
      ld_valid     <= 1'b0;
      ld_data      <= '0;
      misalign     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_misalign) begin
              misalign <= 1'b1;
              state_q  <= StDone;
            end else begin
              mem_rw_valid <= 1'b1;
              mem_rw_wen   <= req_we;
              mem_rw_addr  <= req_addr;
              mem_rw_wdata <= req_wdata << {req_addr[2:0], 3'b000};
              mem_rw_wmask <= req_we ? req_wmask : 8'h00;
              width_q      <= req_width;
              state_q      <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_rw_ready) begin
            mem_rw_valid <= 1'b0;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (mem_resp_valid) begin
            if (!mem_rw_wen) begin
              ld_data  <= ld_ext;
              ld_valid <= 1'b1;
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          ld_valid <= 1'b0;
          misalign <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table driven through a bus responder,
// scoreboard of expected results, plus reset-in-WAIT and back-to-back sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic [2:0]  req_width;
  logic        req_stall, ld_valid, misalign;
  logic [63:0] ld_data;
  logic        mem_rw_valid, mem_rw_ready, mem_rw_wen;
  logic [63:0] mem_rw_addr, mem_rw_wdata;
  logic [7:0]  mem_rw_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wmask     (req_wmask),
    .req_width     (req_width),
    .req_stall     (req_stall),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .misalign      (misalign),
    .mem_rw_valid  (mem_rw_valid),
    .mem_rw_ready  (mem_rw_ready),
    .mem_rw_wen    (mem_rw_wen),
    .mem_rw_addr   (mem_rw_addr),
    .mem_rw_wdata  (mem_rw_wdata),
    .mem_rw_wmask  (mem_rw_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [2:0]  width;
    logic [63:0] rdata;
    int          rdly;
    int          sdly;
    bit          inject;
    bit          mis;
    logic [63:0] ld;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
  } vec_t;

  typedef struct {
    bit          mis;
    bit          is_ld;
    logic [63:0] ld;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  vec_t        vt[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] ld_model;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v);
    exp_t        e;
    int          stalls = 0, vcyc = 0, wcyc = 0;
    bit          saw_v = 0, in_wait = 0, hs = 0, unstable = 0, done = 0, early = 0;
    logic        c_wen;
    logic [63:0] c_addr, c_wdata;
    logic [7:0]  c_wmask;
    c_wen = 1'b0; c_addr = '0; c_wdata = '0; c_wmask = '0;
    e.mis    = v.mis;
    e.is_ld  = !v.we && !v.mis;
    e.ld     = e.is_ld ? v.ld : ld_model;
    e.we     = v.we;
    e.addr   = v.addr;
    e.wdata  = v.bus_wdata;
    e.wmask  = v.bus_wmask;
    e.stalls = v.mis ? 1 : 3 + v.rdly + v.sdly;
    sb.push_back(e);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_wdata = v.wdata; req_wmask = v.wmask; req_width = v.width;
    #1;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (!req_stall) begin
        done = 1;
      end else begin
        stalls++;
        if (ld_valid || misalign) early = 1;
        if (hs) begin
          in_wait = 1; hs = 0; mem_rw_ready = 1'b0;
        end
        if (mem_rw_valid) begin
          if (!saw_v) begin
            c_wen = mem_rw_wen; c_addr = mem_rw_addr; c_wdata = mem_rw_wdata;
            c_wmask = mem_rw_wmask;
          end else if ({c_wen, c_addr, c_wdata, c_wmask} !==
                       {mem_rw_wen, mem_rw_addr, mem_rw_wdata, mem_rw_wmask}) begin
            unstable = 1;
          end
          saw_v          = 1;
          mem_rw_ready   = (vcyc >= v.rdly);
          hs             = mem_rw_ready;
          vcyc++;
          mem_resp_valid = v.inject;
          mem_resp_rdata = ~v.rdata;
        end else if (in_wait) begin
          mem_resp_valid = (wcyc >= v.sdly);
          mem_resp_rdata = v.rdata;
          wcyc++;
        end
      end
    end
    mem_resp_valid = 1'b0; mem_rw_ready = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: access at %h never reached DONE", v.addr);
    end
    e = sb.pop_front();
    chk("misalign", misalign, e.mis);
    chk("ld_valid", ld_valid, e.is_ld);
    chk("ld_data", ld_data, e.ld);
    chk("stall_cycles", stalls, e.stalls);
    chk("early_pulse", early, 0);
    chk("bus_used", saw_v, !e.mis);
    if (!e.mis) begin
      chk("wen", c_wen, e.we);
      chk("addr", c_addr, e.addr);
      chk("wdata", c_wdata, e.wdata);
      chk("wmask", c_wmask, e.wmask);
      chk("req_stable", unstable, 0);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("pulse_width", {ld_valid, misalign, mem_rw_valid}, 3'b000);
    ld_model = e.ld;
  endtask

  initial begin
    logic [3:0] pat_s, pat_m;
    bit         bad;
    rst = 1'b1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    req_wmask = '0; req_width = '0; mem_rw_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    ld_model = '0;

    vt.push_back('{1'b1, 64'h1003, 64'hAB, 8'h08, 3'd4, 64'h0, 0, 0, 1'b0, 1'b0, 64'h0,
                   64'h00000000AB000000, 8'h08});
    vt.push_back('{1'b0, 64'h2006, 64'h0, 8'hC0, 3'd3, 64'h8001000000000000, 0, 0, 1'b0,
                   1'b0, 64'hFFFFFFFFFFFF8001, 64'h0, 8'h00});
    vt.push_back('{1'b0, 64'h2004, 64'h0, 8'hF0, 3'd5, 64'hDEADBEEF00000000, 0, 0, 1'b0,
                   1'b0, 64'h00000000DEADBEEF, 64'h0, 8'h00});
    vt.push_back('{1'b0, 64'h2007, 64'h0, 8'h80, 3'd7, 64'hDEADBEEF00000000, 0, 0, 1'b0,
                   1'b0, 64'h00000000000000DE, 64'h0, 8'h00});
    vt.push_back('{1'b0, 64'h3002, 64'h0, 8'h3C, 3'd2, 64'h0, 0, 0, 1'b0, 1'b1, 64'h0,
                   64'h0, 8'h00});
    vt.push_back('{1'b1, 64'h4000, 64'h0123456789ABCDEF, 8'hFF, 3'd1, 64'h0, 5, 0, 1'b1,
                   1'b0, 64'h0, 64'h0123456789ABCDEF, 8'hFF});
    vt.push_back('{1'b0, 64'h2000, 64'h0, 8'h01, 3'd4, 64'h1122334455667788, 1, 2, 1'b0,
                   1'b0, 64'hFFFFFFFFFFFFFF88, 64'h0, 8'h00});
    vt.push_back('{1'b0, 64'h2004, 64'h0, 8'hF0, 3'd2, 64'h8000000000000000, 2, 1, 1'b1,
                   1'b0, 64'hFFFFFFFF80000000, 64'h0, 8'h00});
    vt.push_back('{1'b0, 64'h2008, 64'h0, 8'hFF, 3'd1, 64'hCAFEBABE12345678, 0, 0, 1'b0,
                   1'b0, 64'hCAFEBABE12345678, 64'h0, 8'h00});
    vt.push_back('{1'b0, 64'h2002, 64'h0, 8'h0C, 3'd6, 64'h00000000F00D0000, 0, 0, 1'b0,
                   1'b0, 64'h000000000000F00D, 64'h0, 8'h00});
    vt.push_back('{1'b1, 64'h100A, 64'h1234, 8'h0C, 3'd3, 64'h0, 0, 0, 1'b0, 1'b0, 64'h0,
                   64'h0000000012340000, 8'h0C});
    vt.push_back('{1'b1, 64'h1004, 64'h87654321, 8'hF0, 3'd2, 64'h0, 0, 3, 1'b0, 1'b0,
                   64'h0, 64'h8765432100000000, 8'hF0});
    vt.push_back('{1'b0, 64'h6000, 64'h0, 8'h01, 3'd0, 64'h0, 0, 0, 1'b0, 1'b1, 64'h0,
                   64'h0, 8'h00});
    vt.push_back('{1'b0, 64'h6004, 64'h0, 8'hF0, 3'd1, 64'h0, 0, 0, 1'b0, 1'b1, 64'h0,
                   64'h0, 8'h00});
    vt.push_back('{1'b1, 64'h6001, 64'h0, 8'h06, 3'd3, 64'h0, 0, 0, 1'b0, 1'b1, 64'h0,
                   64'h0, 8'h00});
    vt.push_back('{1'b0, 64'h6006, 64'h0, 8'hC0, 3'd5, 64'h0, 0, 0, 1'b0, 1'b1, 64'h0,
                   64'h0, 8'h00});

    repeat (2) @(negedge clk);
    chk("reset_outputs", {mem_rw_valid, mem_rw_wen, mem_rw_addr, mem_rw_wdata, mem_rw_wmask,
                          ld_valid, ld_data, misalign, req_stall}, '0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vt[i]) do_access(vt[i]);

    // Back-to-back rejected accesses: accept, DONE, accept again, DONE.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h7001; req_width = 3'd2;
    #1;
    pat_s[3] = req_stall; pat_m[3] = misalign;
    for (int k = 2; k >= 0; k--) begin
      @(negedge clk);
      pat_s[k] = req_stall; pat_m[k] = misalign;
    end
    chk("b2b_stall", pat_s, 4'b1010);
    chk("b2b_misalign", pat_m, 4'b0101);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_ld_keep", ld_data, ld_model);

    // Reset while waiting for a load response; the stale response must be dropped.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h5000; req_width = 3'd1;
    @(negedge clk);
    chk("rst_seq_req", mem_rw_valid, 1'b1);
    mem_rw_ready = 1'b1;
    @(negedge clk);
    mem_rw_ready = 1'b0;
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("rst_wait_outputs", {mem_rw_valid, mem_rw_wen, mem_rw_addr, mem_rw_wdata, mem_rw_wmask,
                             ld_valid, ld_data, misalign, req_stall}, '0);
    rst = 1'b0;
    ld_model = '0;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hBAD0BAD0BAD0BAD0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (ld_valid || mem_rw_valid || ld_data != 64'h0) bad = 1;
    end
    chk("stale_resp_ignored", bad, 0);
    do_access('{1'b0, 64'h5000, 64'h0, 8'hFF, 3'd1, 64'h0123456789ABCDEF, 0, 0, 1'b0, 1'b0,
                64'h0123456789ABCDEF, 64'h0, 8'h00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
